// File: rtl/lmg_sequencer.sv
// ---------------------------------------------------------------------------
// lmg_sequencer
//   Control sequencer for a column-unit move generator. On a newboard request
//   it loads the eight board columns into the column-unit array, lets the
//   array propagate for PROP_CYCLES clocks, and then scans all 64 source
//   squares. Each destination bit reported for a square is offered as one
//   move on a valid/ready handshake, lowest destination index first.
//
// Parameters
//   PROP_CYCLES  propagation clocks after board load (legal 1..15)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   newboard     single-cycle start request, honoured only in IDLE
//   load_en      column-unit array latches column load_col this cycle
//   load_col     column index being loaded (0..7)
//   prop_en      column-unit array propagates this cycle
//   sq_addr      source square being scanned, {col,row}
//   dst_mask     destination bitmap for sq_addr (combinational from array)
//   move_valid   move_from/move_to hold a move
//   move_ready   consumer accepts the offered move this cycle
//   move_from    source square of the offered move
//   move_to      destination square of the offered move
//   move_count   moves accepted since the last start, saturating at 255
//   busy         high in every state except IDLE
//   done         one-cycle pulse on the first IDLE cycle after a full scan
// ---------------------------------------------------------------------------
module lmg_sequencer #(
    parameter int unsigned PROP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newboard,
    output logic        load_en,
    output logic [2:0]  load_col,
    output logic        prop_en,
    output logic [5:0]  sq_addr,
    input  logic [63:0] dst_mask,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [5:0]  move_from,
    output logic [5:0]  move_to,
    output logic [7:0]  move_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROP,
        SCAN,
        EMIT
    } state_t;

    localparam logic [3:0] PROP_LAST = 4'(PROP_CYCLES - 1);

    state_t      state;
    logic [3:0]  prop_cnt;
    logic [63:0] pending;
    logic [63:0] remaining;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [5:0] lowest_bit(input logic [63:0] v);
        logic [5:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (v[i[5:0]] && !found) begin
                r     = i[5:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Destinations still owed for the current square once the offered move
    // is accepted.
    always_comb begin
        remaining = pending & ~(64'd1 << move_to);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prop_cnt   <= '0;
            pending    <= '0;
            load_en    <= 1'b0;
            load_col   <= '0;
            prop_en    <= 1'b0;
            sq_addr    <= '0;
            move_valid <= 1'b0;
            move_from  <= '0;
            move_to    <= '0;
            move_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (newboard) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        load_en    <= 1'b1;
                        load_col   <= '0;
                        sq_addr    <= '0;
                        prop_cnt   <= '0;
                        move_count <= '0;
                    end
                end

                LOAD: begin
                    if (load_col == 3'd7) begin
                        state    <= PROP;
                        load_en  <= 1'b0;
                        load_col <= '0;
                        prop_en  <= 1'b1;
                        prop_cnt <= '0;
                    end else begin
                        load_col <= load_col + 3'd1;
                    end
                end

                PROP: begin
                    if (prop_cnt == PROP_LAST) begin
                        state   <= SCAN;
                        prop_en <= 1'b0;
                        sq_addr <= '0;
                    end else begin
                        prop_cnt <= prop_cnt + 4'd1;
                    end
                end

                SCAN: begin
                    pending <= dst_mask;
                    if (dst_mask == '0) begin
                        if (sq_addr == 6'd63) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            sq_addr <= '0;
                        end else begin
                            sq_addr <= sq_addr + 6'd1;
                        end
                    end else begin
                        state      <= EMIT;
                        move_valid <= 1'b1;
                        move_from  <= sq_addr;
                        move_to    <= lowest_bit(dst_mask);
                    end
                end

                EMIT: begin
                    if (move_ready) begin
                        if (move_count != 8'hFF) begin
                            move_count <= move_count + 8'd1;
                        end
                        pending <= remaining;
                        if (remaining != '0) begin
                            move_to <= lowest_bit(remaining);
                        end else begin
                            move_valid <= 1'b0;
                            move_from  <= '0;
                            move_to    <= '0;
                            if (sq_addr == 6'd63) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                sq_addr <= '0;
                            end else begin
                                state   <= SCAN;
                                sq_addr <= sq_addr + 6'd1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
